// File: rtl/arb138_pkg.sv
// Shared definitions for the 74LS138 round-robin arbiter: sizes, FSM state
// codes and the round-robin winner search.
package arb138_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_GRANT = 2'd1;
    localparam logic [1:0] ST_GAP   = 2'd2;

    // First set request bit at or above ptr, wrapping 7 -> 0.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [SEL_W-1:0] ptr);
        logic [SEL_W-1:0] idx;
        logic             found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = ptr + SEL_W'(k);
            if (!found && req[idx]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/decode138.sv
// 74LS138-style 3-to-8 decoder: active-low outputs, enabled by E1 & ~E2_n & ~E3_n.
module decode138 (
    input  logic       A0,
    input  logic       A1,
    input  logic       A2,
    input  logic       E1,
    input  logic       E2_n,
    input  logic       E3_n,
    output logic [7:0] Y_n
);

    logic       w_en;
    logic [2:0] w_sel;

    assign w_en  = E1 & ~E2_n & ~E3_n;
    assign w_sel = {A2, A1, A0};

    always_comb begin
        Y_n = '1;
        if (w_en) begin
            Y_n[w_sel] = 1'b0;
        end
    end

endmodule

// File: rtl/arb138_rr.sv
// Round-robin arbiter driving a shared 138 decoder; grants are bounded by
// HOLD_MAX cycles and separated by a one-cycle break-before-make gap.
module arb138_rr
    import arb138_pkg::*;
#(
    parameter int HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] req,
    output logic       A0,
    output logic       A1,
    output logic       A2,
    output logic       E1,
    output logic       E2_n,
    output logic       E3_n,
    output logic [7:0] grant_n,
    output logic       busy,
    output logic       timeout
);

    localparam int CNT_W = (HOLD_MAX > 2) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(HOLD_MAX - 1);

    logic [1:0]       r_state;
    logic [SEL_W-1:0] r_ptr;
    logic [SEL_W-1:0] r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic             r_e1;
    logic             r_e2_n;
    logic             r_e3_n;
    logic             r_timeout;

    logic [SEL_W-1:0] w_winner;
    logic             w_sel_req;

    assign w_winner  = rr_pick(req, r_ptr);
    assign w_sel_req = req[r_sel];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_ptr     <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_e1      <= 1'b0;
            r_e2_n    <= 1'b1;
            r_e3_n    <= 1'b1;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // The first edge after reset only opens the active-low enables.
                    if (r_e2_n || r_e3_n) begin
                        r_e2_n <= 1'b0;
                        r_e3_n <= 1'b0;
                    end else if (|req) begin
                        r_sel   <= w_winner;
                        r_e1    <= 1'b1;
                        r_cnt   <= '0;
                        r_state <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (!w_sel_req || (r_cnt == CNT_LIMIT)) begin
                        r_e1      <= 1'b0;
                        r_ptr     <= r_sel + SEL_W'(1);
                        r_state   <= ST_GAP;
                        r_timeout <= w_sel_req;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_GAP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    decode138 u_dec (
        .A0   (r_sel[0]),
        .A1   (r_sel[1]),
        .A2   (r_sel[2]),
        .E1   (r_e1),
        .E2_n (r_e2_n),
        .E3_n (r_e3_n),
        .Y_n  (grant_n)
    );

    assign A0      = r_sel[0];
    assign A1      = r_sel[1];
    assign A2      = r_sel[2];
    assign E1      = r_e1;
    assign E2_n    = r_e2_n;
    assign E3_n    = r_e3_n;
    assign busy    = (r_state != ST_IDLE);
    assign timeout = r_timeout;

endmodule

// File: tb/tb_arb138_rr.sv
// Directed bench for arb138_rr with HOLD_MAX = 16, 4 and 3 instances sharing clk/rst.
module tb_arb138_rr;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] req16 = '0;
    logic [7:0] req4  = '0;
    logic [7:0] req3  = '0;

    logic a0_16, a1_16, a2_16, e1_16, e2n_16, e3n_16, busy16, to16;
    logic a0_4,  a1_4,  a2_4,  e1_4,  e2n_4,  e3n_4,  busy4,  to4;
    logic a0_3,  a1_3,  a2_3,  e1_3,  e2n_3,  e3n_3,  busy3,  to3;
    logic [7:0] gn16, gn4, gn3;
    logic [2:0] a16, a4;

    int n_pass  = 0;
    int n_total = 0;

    assign a16 = {a2_16, a1_16, a0_16};
    assign a4  = {a2_4, a1_4, a0_4};

    always #5 clk = ~clk;

    arb138_rr #(.HOLD_MAX(16)) u_dut16 (
        .clk(clk), .rst(rst), .req(req16),
        .A0(a0_16), .A1(a1_16), .A2(a2_16),
        .E1(e1_16), .E2_n(e2n_16), .E3_n(e3n_16),
        .grant_n(gn16), .busy(busy16), .timeout(to16)
    );

    arb138_rr #(.HOLD_MAX(4)) u_dut4 (
        .clk(clk), .rst(rst), .req(req4),
        .A0(a0_4), .A1(a1_4), .A2(a2_4),
        .E1(e1_4), .E2_n(e2n_4), .E3_n(e3n_4),
        .grant_n(gn4), .busy(busy4), .timeout(to4)
    );

    arb138_rr #(.HOLD_MAX(3)) u_dut3 (
        .clk(clk), .rst(rst), .req(req3),
        .A0(a0_3), .A1(a1_3), .A2(a2_3),
        .E1(e1_3), .E2_n(e2n_3), .E3_n(e3n_3),
        .grant_n(gn3), .busy(busy3), .timeout(to3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        req16 = '0;
        req4  = '0;
        req3  = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        req16 = '0;
        tick();
        n_total++;
        if ({a16, e1_16, e2n_16, e3n_16} !== 6'b000_011) $display("FAIL reset_lines: got %b expected %b", {a16, e1_16, e2n_16, e3n_16}, 6'b000011);
        else n_pass++;
        n_total++;
        if ({gn16, busy16, to16} !== {8'hFF, 2'b00}) $display("FAIL reset_outs: got %h expected %h", {gn16, busy16, to16}, {8'hFF, 2'b00});
        else n_pass++;
        req16 = 8'h01;
        tick();
        rst = 1'b0;
        tick();
        n_total++;
        if ({e1_16, e2n_16, e3n_16, gn16} !== {3'b000, 8'hFF}) $display("FAIL first_edge_no_grant: got %h expected %h", {e1_16, e2n_16, e3n_16, gn16}, {3'b000, 8'hFF});
        else n_pass++;
        tick();
        n_total++;
        if (gn16 !== 8'hFE) $display("FAIL grant_after_enable: got %h expected %h", gn16, 8'hFE);
        else n_pass++;
    endtask

    task automatic test_single();
        do_reset();
        req16 = 8'h08;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_total++;
            if ({a16, gn16, busy16} !== {3'b011, 8'hF7, 1'b1}) $display("FAIL single_grant[%0d]: got %h expected %h", i, {a16, gn16, busy16}, {3'b011, 8'hF7, 1'b1});
            else n_pass++;
        end
        req16 = 8'h00;
        tick();
        n_total++;
        if ({gn16, busy16, to16} !== {8'hFF, 2'b10}) $display("FAIL single_gap: got %h expected %h", {gn16, busy16, to16}, {8'hFF, 2'b10});
        else n_pass++;
        tick();
        n_total++;
        if ({gn16, busy16} !== {8'hFF, 1'b0}) $display("FAIL single_idle: got %h expected %h", {gn16, busy16}, {8'hFF, 1'b0});
        else n_pass++;
    endtask

    task automatic test_fairness();
        logic [7:0] exp_gn;
        int unsigned seq[4] = '{0, 7, 0, 7};
        do_reset();
        req4 = 8'h81;
        for (int g = 0; g < 4; g++) begin
            exp_gn = ~(8'h01 << seq[g]);
            for (int c = 0; c < 4; c++) begin
                tick();
                n_total++;
                if ({gn4, to4} !== {exp_gn, 1'b0}) $display("FAIL rr_grant[%0d.%0d]: got %h expected %h", g, c, {gn4, to4}, {exp_gn, 1'b0});
                else n_pass++;
            end
            tick();
            n_total++;
            if ({gn4, to4, busy4} !== {8'hFF, 2'b11}) $display("FAIL rr_gap_timeout[%0d]: got %h expected %h", g, {gn4, to4, busy4}, {8'hFF, 2'b11});
            else n_pass++;
            tick();
            n_total++;
            if ({gn4, to4, busy4} !== {8'hFF, 2'b00}) $display("FAIL rr_idle[%0d]: got %h expected %h", g, {gn4, to4, busy4}, {8'hFF, 2'b00});
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        req4 = 8'h20;
        tick();
        n_total++;
        if (a4 !== 3'd5) $display("FAIL wrap_first: got %0d expected %0d", a4, 5);
        else n_pass++;
        req4 = 8'h00;
        tick();
        tick();
        req4 = 8'h05;
        tick();
        n_total++;
        if ({a4, gn4} !== {3'd0, 8'hFE}) $display("FAIL wrap_to0: got %h expected %h", {a4, gn4}, {3'd0, 8'hFE});
        else n_pass++;
        for (int i = 0; i < 5; i++) tick();
        tick();
        n_total++;
        if ({a4, gn4} !== {3'd2, 8'hFB}) $display("FAIL wrap_to2: got %h expected %h", {a4, gn4}, {3'd2, 8'hFB});
        else n_pass++;
    endtask

    task automatic test_release_vs_limit();
        do_reset();
        req3 = 8'h04;
        tick();
        tick();
        tick();
        n_total++;
        if ({e1_3, gn3} !== {1'b1, 8'hFB}) $display("FAIL rl_held: got %h expected %h", {e1_3, gn3}, {1'b1, 8'hFB});
        else n_pass++;
        req3 = 8'h00;
        tick();
        n_total++;
        if ({e1_3, to3, busy3} !== 3'b001) $display("FAIL rl_release_wins: got %b expected %b", {e1_3, to3, busy3}, 3'b001);
        else n_pass++;
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req16 = 8'h04;
        tick();
        n_total++;
        if (gn16 !== 8'hFB) $display("FAIL mid_pre: got %h expected %h", gn16, 8'hFB);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_total++;
        if ({a16, e1_16, e2n_16, e3n_16, gn16, busy16, to16} !== {6'b000011, 8'hFF, 2'b00})
            $display("FAIL mid_async_reset: got %h expected %h", {a16, e1_16, e2n_16, e3n_16, gn16, busy16, to16}, {6'b000011, 8'hFF, 2'b00});
        else n_pass++;
        req16 = 8'h01;
        tick();
        rst = 1'b0;
        tick();
        n_total++;
        if ({e1_16, gn16} !== {1'b0, 8'hFF}) $display("FAIL mid_enable_edge: got %h expected %h", {e1_16, gn16}, {1'b0, 8'hFF});
        else n_pass++;
        tick();
        n_total++;
        if ({a16, gn16} !== {3'd0, 8'hFE}) $display("FAIL mid_pending: got %h expected %h", {a16, gn16}, {3'd0, 8'hFE});
        else n_pass++;
    endtask

    task automatic test_decode();
        logic [7:0] exp_gn;
        for (int i = 0; i < 8; i++) begin
            do_reset();
            req16  = 8'h01 << i;
            exp_gn = ~(8'h01 << i);
            tick();
            n_total++;
            if ({e1_16, gn16} !== {1'b1, exp_gn}) $display("FAIL decode[%0d]: got %h expected %h", i, {e1_16, gn16}, {1'b1, exp_gn});
            else n_pass++;
            req16 = 8'h00;
            tick();
            n_total++;
            if (gn16 !== 8'hFF) $display("FAIL decode_gap[%0d]: got %h expected %h", i, gn16, 8'hFF);
            else n_pass++;
            tick();
            n_total++;
            if (gn16 !== 8'hFF) $display("FAIL decode_idle[%0d]: got %h expected %h", i, gn16, 8'hFF);
            else n_pass++;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_release_vs_limit();
        test_reset_mid_grant();
        test_decode();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
